// File: rtl/match_logger_if.sv
// Reader-side handshake for match_logger: the head timestamp offered with ready/valid.
// The logger drives through the master modport; the draining logic uses the slave modport.
interface match_logger_if #(
    parameter int TS_W = 16
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_ts;

    modport master (
        output rd_valid,
        output rd_ts,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_ts,
        output rd_ready
    );
endinterface

// File: rtl/match_logger.sv
// Timestamps each detector match into a first-word-fall-through FIFO, with a saturating
// match count and sticky overflow. Optional MATCH_LOGGER_DROP_CNT_EN adds a drop counter.
module match_logger #(
    parameter  int DEPTH = 8,
    parameter  int TS_W  = 16,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              match,
    input  logic              ts_clear,
    input  logic              clr_overflow,
    match_logger_if.master    rd,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [CNT_W-1:0]  match_count,
`ifdef MATCH_LOGGER_DROP_CNT_EN
    output logic [CNT_W-1:0]  drop_count,
`endif
    output logic              overflow
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    // A pop frees the head slot on the same edge, so a full FIFO still accepts a push then.
    assign full  = (fifo_level == LVL_W'(DEPTH));
    assign empty = (fifo_level == '0);
    assign pop   = ~empty & rd.rd_ready;
    assign push  = match & (~full | pop);
    assign drop  = match & full & ~pop;

    assign rd.rd_valid = ~empty;
    assign rd.rd_ts    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else if (ts_clear) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Storage carries no reset; validity comes entirely from fifo_level.
    always_ff @(posedge clk) begin
        if (~reset && push) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (match) begin
            match_count <= sat_inc(match_count);
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef MATCH_LOGGER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clr_overflow) begin
            drop_count <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            drop_count <= sat_inc(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_match_logger.sv
// Bench for match_logger: a wide instance (TS_W=16, CNT_W=8) and a narrow one (TS_W=4, CNT_W=3)
// share one stimulus stream and one queue-based reference model.
module tb_match_logger;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic match = 1'b0;
    logic ts_clear = 1'b0;
    logic clr_overflow = 1'b0;
    logic rd_ready = 1'b0;

    always #5 clk = ~clk;

    match_logger_if #(.TS_W(16)) rif0 ();
    match_logger_if #(.TS_W(4))  rif1 ();
    assign rif0.rd_ready = rd_ready;
    assign rif1.rd_ready = rd_ready;

    logic [3:0] fifo_level0, fifo_level1;
    logic [7:0] match_count0;
    logic [2:0] match_count1;
    logic       overflow0, overflow1;
`ifdef MATCH_LOGGER_DROP_CNT_EN
    logic [7:0] drop_count0;
    logic [2:0] drop_count1;
`endif

    match_logger #(.DEPTH(DEPTH), .TS_W(16), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .match(match), .ts_clear(ts_clear),
        .clr_overflow(clr_overflow), .rd(rif0.master), .fifo_level(fifo_level0),
        .match_count(match_count0),
`ifdef MATCH_LOGGER_DROP_CNT_EN
        .drop_count(drop_count0),
`endif
        .overflow(overflow0)
    );

    match_logger #(.DEPTH(DEPTH), .TS_W(4), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .match(match), .ts_clear(ts_clear),
        .clr_overflow(clr_overflow), .rd(rif1.master), .fifo_level(fifo_level1),
        .match_count(match_count1),
`ifdef MATCH_LOGGER_DROP_CNT_EN
        .drop_count(drop_count1),
`endif
        .overflow(overflow1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded event/drop totals and a queue of 16-bit stamps.
    // The narrow instance's stamps are the same values modulo 16.
    int mq[$];
    int m_ts  = 0;
    int m_n   = 0;
    int m_d   = 0;
    bit m_ovf = 1'b0;
    bit chk_en = 1'b0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit drop;
        if (reset) begin
            mq.delete();
            m_ts  = 0;
            m_n   = 0;
            m_d   = 0;
            m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && rd_ready;
            drop = 1'b0;
            if (match) begin
                m_n++;
                if (mq.size() == DEPTH && !pop) drop = 1'b1;
            end
            if (clr_overflow) begin
                m_ovf = 1'b0;
                m_d   = 0;
            end
            if (drop) begin
                m_ovf = 1'b1;
                m_d++;
            end
            if (pop) void'(mq.pop_front());
            if (match && !drop) mq.push_back(m_ts);
            m_ts = ts_clear ? 0 : (m_ts + 1) % 65536;
        end
    endtask

    task automatic cyc(input bit m, input bit rr, input bit tc = 1'b0,
                       input bit co = 1'b0, input bit rst = 1'b0);
        match        = m;
        rd_ready     = rr;
        ts_clear     = tc;
        clr_overflow = co;
        reset        = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid0", int'(rif0.rd_valid), int'(mq.size() != 0));
            chk("valid1", int'(rif1.rd_valid), int'(mq.size() != 0));
            chk("level0", int'(fifo_level0), mq.size());
            chk("level1", int'(fifo_level1), mq.size());
            chk("count0", int'(match_count0), sat(m_n, 255));
            chk("count1", int'(match_count1), sat(m_n, 7));
            chk("ovf0", int'(overflow0), int'(m_ovf));
            chk("ovf1", int'(overflow1), int'(m_ovf));
            if (mq.size() != 0) begin
                chk("head0", int'(rif0.rd_ts), mq[0]);
                chk("head1", int'(rif1.rd_ts), mq[0] % 16);
            end
`ifdef MATCH_LOGGER_DROP_CNT_EN
            chk("drop0", int'(drop_count0), sat(m_d, 255));
            chk("drop1", int'(drop_count1), sat(m_d, 7));
`endif
        end
    end

    bit sb[13] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};

    initial begin
        logic [2:0] h;
        int a;
        int b;
        int exp_pop[8];
        int thr;

        // Reset held two cycles with match high
        cyc(1, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(1, 1, 0, 0, 1);
        chk("rst_level", int'(fifo_level0), 0);
        chk("rst_valid", int'(rif0.rd_valid), 0);
        chk("rst_count", int'(match_count0), 0);
        chk("rst_ovf", int'(overflow0), 0);
        chk("rst_rdts", int'(rif0.rd_ts), 0);
        chk("rst_rdts1", int'(rif1.rd_ts), 0);

        // First edge after release leaves ts=1
        cyc(0, 0);
        cyc(1, 0);
        chk("ts_after_rst", int'(rif0.rd_ts), 1);
        cyc(0, 1);
        chk("drain_one", int'(rif0.rd_valid), 0);

        // Detector stream 1101100101101 through a behavioural 1101 detector
        cyc(0, 0, 0, 0, 1);
        h = 3'b000;
        for (int i = 0; i < 13; i++) begin
            cyc(({h, sb[i]} == 4'b1101), 0);
            h = {h[1:0], sb[i]};
        end
        chk("det_level", int'(fifo_level0), 2);
        chk("det_count", int'(match_count0), 2);
        a = int'(rif0.rd_ts);
        chk("det_first", a, 3);
        cyc(0, 1);
        b = int'(rif0.rd_ts);
        chk("det_diff", b - a, 9);
        cyc(0, 1);

        // Overflow: ten matches into an 8-deep FIFO with no reader
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 0);
        chk("sat9_count1", int'(match_count1), 7);
        cyc(1, 0);
        chk("ovf_level", int'(fifo_level0), 8);
        chk("ovf_count", int'(match_count0), 10);
        chk("ovf_flag", int'(overflow0), 1);
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("ovf_drops", int'(drop_count0), 2);
`endif
        // Full with a simultaneous pop at ts=10
        cyc(1, 1);
        chk("fullpop_level", int'(fifo_level0), 8);
        chk("fullpop_ovf", int'(overflow0), 1);
        // Clear racing a drop at ts=11
        cyc(1, 0, 0, 1);
        chk("clrrace_ovf", int'(overflow0), 1);
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("clrrace_drop", int'(drop_count0), 1);
`endif
        cyc(0, 0, 0, 1);
        chk("clr_ovf", int'(overflow0), 0);
        exp_pop = '{1, 2, 3, 4, 5, 6, 7, 10};
        for (int i = 0; i < 8; i++) begin
            chk("pop_seq0", int'(rif0.rd_ts), exp_pop[i]);
            chk("pop_seq1", int'(rif1.rd_ts), exp_pop[i] % 16);
            cyc(0, 1);
        end
        chk("drained", int'(rif0.rd_valid), 0);

        // ts_clear racing a match at ts=0x0042, then wrap of the 4-bit stamp
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 66; i++) cyc(0, 0);
        cyc(1, 0, 1);
        cyc(1, 0);
        chk("tsclr_entry", int'(rif0.rd_ts), 'h42);
        chk("tsclr_entry1", int'(rif1.rd_ts), 2);
        cyc(0, 1);
        chk("tsclr_next", int'(rif0.rd_ts), 0);
        cyc(0, 1);

        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(0, 0);
        cyc(1, 0);
        cyc(1, 0);
        chk("wrap_a", int'(rif1.rd_ts), 15);
        cyc(0, 1);
        chk("wrap_b", int'(rif1.rd_ts), 0);
        chk("wrap_b_wide", int'(rif0.rd_ts), 16);
        cyc(0, 1);

        // Randomized traffic with alternating reader pressure
        for (int i = 0; i < 4000; i++) begin
            thr = ((i / 400) % 2) ? 75 : 25;
            cyc($urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < thr,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 5,
                $urandom_range(0, 999) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
